filter_weight_loader: RTL and testbench
=======================================

FILTER_WEIGHT_LOADER -- requirements
Module: filter_weight_loader

Interface
REQ-001 The block SHALL have parameter NUM_FILTERS, default 4, giving the number of 3x3 filters stored.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, giving the width of each weight and bias word.
REQ-003 The block SHALL have parameter FILT_IDX_W, default 2, giving the width of the filter index; it SHALL satisfy 2^FILT_IDX_W >= NUM_FILTERS.
REQ-004 The block SHALL use one clock, clk; reset is rst, asynchronous and active-high.
REQ-005 The ports SHALL be, in this order:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a load session.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader accepts a word.
- in_data  in  DATA_WIDTH  weight or bias word.
- in_last  in  1  marks the final word of the session.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky framing error.
- loaded  out  1  memory holds a complete, valid set.
- rd_en  in  1  read request.
- rd_filter  in  FILT_IDX_W  filter to read.
- rdata0..rdata8  out  DATA_WIDTH each  the nine weights, row-major.
- bias  out  DATA_WIDTH  filter bias.

Function
REQ-006 Storage SHALL be NUM_FILTERS*10 words; filter f, word k (k=0..8 weights, k=9 bias) SHALL be held at index f*10+k. TOTAL = NUM_FILTERS*10.
REQ-007 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-008 IDLE: in_ready=0 and busy=0; start=1 SHALL go to LOAD, clear the word counter, clear err and clear loaded.
REQ-009 LOAD: in_ready=1 and busy=1; each cycle with in_valid&in_ready SHALL write in_data to mem[cnt] and increment cnt.
REQ-010 In LOAD, a handshake at cnt=TOTAL-1 with in_last=1 SHALL go to DONE and set loaded=1 on the same clock edge.
REQ-011 In LOAD, a handshake at cnt=TOTAL-1 with in_last=0 SHALL write the word, set err=1, leave loaded=0, and go to DONE.
REQ-012 In LOAD, a handshake at cnt<TOTAL-1 with in_last=1 SHALL write the word, set err=1, leave loaded=0, and go to DONE.
REQ-013 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-014 done SHALL assert the cycle after the final handshake.
REQ-015 start SHALL be ignored in LOAD and DONE.
REQ-016 in_valid SHALL be ignored outside LOAD.
REQ-017 err and loaded SHALL hold their values until the next start or reset.
REQ-018 Read port: when rd_en=1, rdata0..8 and bias SHALL register mem[rd_filter*10+0..9] on the next clk edge (1-cycle latency); when rd_en=0 the outputs SHALL hold.
REQ-019 If rd_filter >= NUM_FILTERS with rd_en=1, all read outputs SHALL register 0.
REQ-020 Reads SHALL be permitted in any state; a same-cycle read and write to the same entry SHALL return the old value.
REQ-021 Word order in the stream SHALL be filter 0 word 0 first, then ascending index.

Reset
REQ-022 On rst=1, the state SHALL be IDLE; cnt, all storage words, rdata0..8, bias, in_ready, busy, done, err and loaded SHALL be 0.
REQ-023 rst asserted mid-LOAD SHALL abort the session with no done pulse, and loaded SHALL read 0 after reset.

Verification
REQ-024 Nominal load: NUM_FILTERS=4, start, then 40 words of value 0x0100+i with in_last on word 39 -> done pulses one cycle after word 39, loaded=1, err=0; rd_filter=2 gives rdata0=0x0114 and bias=0x011D one cycle later.
REQ-025 Gapped valid: drop in_valid for 3 cycles between words 5 and 6 -> no write during the gap; final contents equal to the nominal load.
REQ-026 Early last: in_last on word 12 -> err=1 and loaded=0, done pulse, return to IDLE with in_ready=0.
REQ-027 Missing last: 40 words with in_last=0 -> err=1, loaded=0, word 40 never accepted.
REQ-028 Reset mid-load: rst after 17 words -> no done pulse; all outputs and memory 0; a new start and full load then succeeds.
REQ-029 Read edge cases: rd_filter=3 and rd_filter=4 with NUM_FILTERS=4 -> filter 3 data, then all zeros; a read of entry 0 during the write of entry 0 returns the old value.

Source files
------------

// File: rtl/filter_weight_loader.sv
// Filter weight loader: streams NUM_FILTERS 3x3 filters (nine weights plus one
// bias each) into a word memory, flags framing errors, and serves registered
// per-filter reads of all ten words at once.
module filter_weight_loader #(
    parameter int NUM_FILTERS = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int FILT_IDX_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  loaded,
    input  logic                  rd_en,
    input  logic [FILT_IDX_W-1:0] rd_filter,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic [DATA_WIDTH-1:0] rdata3,
    output logic [DATA_WIDTH-1:0] rdata4,
    output logic [DATA_WIDTH-1:0] rdata5,
    output logic [DATA_WIDTH-1:0] rdata6,
    output logic [DATA_WIDTH-1:0] rdata7,
    output logic [DATA_WIDTH-1:0] rdata8,
    output logic [DATA_WIDTH-1:0] bias
);

    localparam int WORDS_PER_FILT = 10;
    localparam int TOTAL          = NUM_FILTERS * WORDS_PER_FILT;
    // TOTAL is a multiple of 10 and never a power of two, so this width both
    // indexes every memory word and can hold TOTAL itself.
    localparam int CNT_W          = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    loaded_q, loaded_d;
    logic                    wr_en;

    logic [DATA_WIDTH-1:0]   mem_q   [TOTAL];
    logic [DATA_WIDTH-1:0]   rdata_q [WORDS_PER_FILT];
    logic [DATA_WIDTH-1:0]   rd_word [WORDS_PER_FILT];
    int unsigned             rd_sel;
    int unsigned             rd_base;
    logic                    rd_ok;

    // Control state, word counter and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            loaded_q <= loaded_d;
        end
    end

    // Session sequencing: handshake, framing checks and status updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        loaded_d = loaded_q;
        wr_en    = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    loaded_d = 1'b0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(TOTAL - 1)) begin
                        state_d = DONE;
                        if (in_last) loaded_d = 1'b1;
                        else         err_d    = 1'b1;
                    end else if (in_last) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Weight/bias storage written in stream order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < TOTAL; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[cnt_q] <= in_data;
        end
    end

    // Select the ten words of the requested filter, zero when out of range.
    always_comb begin
        rd_sel  = 32'(rd_filter);
        rd_base = rd_sel * WORDS_PER_FILT;
        rd_ok   = rd_sel < NUM_FILTERS;
        for (int unsigned k = 0; k < WORDS_PER_FILT; k++) begin
            rd_word[k] = '0;
            if (rd_ok) rd_word[k] = mem_q[CNT_W'(rd_base + k)];
        end
    end

    // Registered read port; memory is sampled before any same-edge write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < WORDS_PER_FILT; k++) rdata_q[k] <= '0;
        end else if (rd_en) begin
            for (int unsigned k = 0; k < WORDS_PER_FILT; k++) rdata_q[k] <= rd_word[k];
        end
    end

    assign err    = err_q;
    assign loaded = loaded_q;
    assign rdata0 = rdata_q[0];
    assign rdata1 = rdata_q[1];
    assign rdata2 = rdata_q[2];
    assign rdata3 = rdata_q[3];
    assign rdata4 = rdata_q[4];
    assign rdata5 = rdata_q[5];
    assign rdata6 = rdata_q[6];
    assign rdata7 = rdata_q[7];
    assign rdata8 = rdata_q[8];
    assign bias   = rdata_q[9];

endmodule

// File: tb/tb_filter_weight_loader.sv
// Randomized self-checking bench for filter_weight_loader against a
// session-level memory/status model.
module tb_filter_weight_loader;

    localparam int NF    = 4;
    localparam int DW    = 16;
    localparam int FIW   = 3;
    localparam int TOTAL = NF * 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          busy;
    logic          done;
    logic          err;
    logic          loaded;
    logic          rd_en;
    logic [FIW-1:0] rd_filter;
    logic [DW-1:0] rdata0, rdata1, rdata2, rdata3, rdata4;
    logic [DW-1:0] rdata5, rdata6, rdata7, rdata8, bias;

    // Reference state: what memory and the status flags should hold.
    logic [DW-1:0] exp_mem [TOTAL];
    logic [DW-1:0] words   [TOTAL + 1];
    logic          exp_err;
    logic          exp_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    filter_weight_loader #(
        .NUM_FILTERS(NF),
        .DATA_WIDTH (DW),
        .FILT_IDX_W (FIW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .loaded   (loaded),
        .rd_en    (rd_en),
        .rd_filter(rd_filter),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .rdata3   (rdata3),
        .rdata4   (rdata4),
        .rdata5   (rdata5),
        .rdata6   (rdata6),
        .rdata7   (rdata7),
        .rdata8   (rdata8),
        .bias     (bias)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd_out(input int k);
        case (k)
            0: return rdata0;
            1: return rdata1;
            2: return rdata2;
            3: return rdata3;
            4: return rdata4;
            5: return rdata5;
            6: return rdata6;
            7: return rdata7;
            8: return rdata8;
            default: return bias;
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_word(input int f, input int k);
        if (f >= NF) return '0;
        return exp_mem[f * 10 + k];
    endfunction

    task automatic check_status(input string tag);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_loaded"}, 32'(loaded), 32'(exp_loaded));
    endtask

    // Read one filter, compare all ten words, then confirm they hold with rd_en low.
    task automatic read_check(input int f);
        rd_en     = 1'b1;
        rd_filter = FIW'(f);
        @(negedge clk);
        rd_en     = 1'b0;
        rd_filter = FIW'($urandom);
        for (int k = 0; k < 10; k++)
            check($sformatf("rd_f%0d_w%0d", f, k), 32'(rd_out(k)), 32'(exp_word(f, k)));
        @(negedge clk);
        check($sformatf("hold_f%0d_w0", f), 32'(rdata0), 32'(exp_word(f, 0)));
        check($sformatf("hold_f%0d_bias", f), 32'(bias), 32'(exp_word(f, 9)));
    endtask

    task automatic verify_all();
        for (int f = 0; f < (1 << FIW); f++) read_check(f);
    endtask

    // One load session. last_at: index carrying in_last (-1 for none).
    // gap_mode: 0 none, 1 three idle cycles before word 6, 2 random idles.
    // abort_after: assert rst once this many words are in (-1 for never).
    task automatic run_session(input int last_at, input int gap_mode,
                               input int abort_after, input bit offer_extra);
        int i;
        int cyc;
        int gaps;
        bit ended;
        bit aborted;
        logic [DW-1:0] old0, old9;
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start      = 1'b0;
        exp_err    = 1'b0;
        exp_loaded = 1'b0;
        check("start_busy", 32'(busy), 1);
        check_status("start");
        i = 0; cyc = 0; gaps = 0; ended = 0; aborted = 0;
        old0 = '0; old9 = '0;
        while (!ended && cyc < 1000) begin
            cyc++;
            check("load_ready", 32'(in_ready), 1);
            check("load_no_done", 32'(done), 0);
            start = ($urandom_range(0, 3) == 0);
            if (abort_after >= 0 && i == abort_after) begin
                in_valid = 1'b0;
                start    = 1'b0;
                rst      = 1'b1;
                #1;
                for (int j = 0; j < TOTAL; j++) exp_mem[j] = '0;
                exp_err    = 1'b0;
                exp_loaded = 1'b0;
                check("abort_busy", 32'(busy), 0);
                check("abort_ready", 32'(in_ready), 0);
                check("abort_done", 32'(done), 0);
                check_status("abort");
                check("abort_rdata0", 32'(rdata0), 0);
                check("abort_bias", 32'(bias), 0);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check("abort_no_done", 32'(done), 0);
                check("abort_idle", 32'(busy), 0);
                ended   = 1;
                aborted = 1;
            end else if ((gap_mode == 1 && i == 6 && gaps < 3) ||
                         (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
                gaps++;
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                in_last  = 1'($urandom);
                @(negedge clk);
            end else begin
                in_valid = 1'b1;
                in_data  = words[i];
                in_last  = (i == last_at);
                if (i == 0) begin
                    rd_en     = 1'b1;
                    rd_filter = '0;
                    old0      = exp_mem[0];
                    old9      = exp_mem[9];
                end
                @(negedge clk);
                rd_en = 1'b0;
                if (i == 0) begin
                    check("rw_same_old_w0", 32'(rdata0), 32'(old0));
                    check("rw_same_old_bias", 32'(bias), 32'(old9));
                end
                exp_mem[i] = words[i];
                if (i == last_at || i == TOTAL - 1) begin
                    ended      = 1;
                    exp_loaded = (i == TOTAL - 1) && (i == last_at);
                    exp_err    = !exp_loaded;
                end
                i++;
            end
        end
        if (!ended) check("session_timeout", 0, 1);
        if (!aborted) begin
            start    = 1'b0;
            in_valid = offer_extra;
            in_data  = words[TOTAL];
            in_last  = 1'b0;
            check("done_pulse", 32'(done), 1);
            check("done_ready", 32'(in_ready), 0);
            check("done_busy", 32'(busy), 0);
            check_status("done");
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("post_no_done", 32'(done), 0);
                check("post_ready", 32'(in_ready), 0);
                check("post_busy", 32'(busy), 0);
            end
            check_status("post");
            in_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        rd_en = 1'b0; rd_filter = '0;
        for (int j = 0; j < TOTAL; j++) exp_mem[j] = '0;
        exp_err = 1'b0; exp_loaded = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_done", 32'(done), 0);
        check_status("rst");
        check("rst_rdata0", 32'(rdata0), 0);
        check("rst_bias", 32'(bias), 0);
        rst = 1'b0;
        @(negedge clk);
        verify_all();

        // Nominal load with the known ramp pattern.
        for (int j = 0; j <= TOTAL; j++) words[j] = DW'(16'h0100 + j);
        run_session(TOTAL - 1, 0, -1, 0);
        rd_en = 1'b1; rd_filter = 3'd2;
        @(negedge clk);
        rd_en = 1'b0;
        check("nominal_f2_w0", 32'(rdata0), 32'h0114);
        check("nominal_f2_bias", 32'(bias), 32'h011D);
        verify_all();

        // Same data with a three-cycle valid gap before word 6.
        run_session(TOTAL - 1, 1, -1, 0);
        verify_all();

        // Early last on word 12.
        for (int j = 0; j <= TOTAL; j++) words[j] = DW'(16'h0200 + j);
        run_session(12, 0, -1, 0);
        verify_all();

        // Missing last, with a 41st word offered afterwards.
        for (int j = 0; j <= TOTAL; j++) words[j] = DW'($urandom);
        run_session(-1, 0, -1, 1);
        verify_all();

        // Randomized sessions mixing good, early-last and missing-last framing.
        for (int s = 0; s < 8; s++) begin
            int sel;
            int last_at;
            for (int j = 0; j <= TOTAL; j++) words[j] = DW'($urandom);
            sel = $urandom_range(0, 2);
            if (sel == 0)      last_at = TOTAL - 1;
            else if (sel == 1) last_at = $urandom_range(0, TOTAL - 2);
            else               last_at = -1;
            run_session(last_at, 2, -1, sel == 2);
            verify_all();
        end

        // in_valid noise while idle must not reach memory.
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            check("idle_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        check_status("idle_noise");
        verify_all();

        // Reset after 17 words, then a full load that must succeed.
        for (int j = 0; j <= TOTAL; j++) words[j] = DW'($urandom);
        run_session(TOTAL - 1, 0, 17, 0);
        verify_all();
        for (int j = 0; j <= TOTAL; j++) words[j] = DW'(16'h0100 + j);
        run_session(TOTAL - 1, 2, -1, 0);
        verify_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
